// File: rtl/panda_load_sequencer.sv
// Drives one PANDA network run: loads engine memories from descriptor-framed
// data streams, pulses start, counts output beats and reports done or timeout.
module panda_load_sequencer #(
    parameter int unsigned ADDR_STRIDE    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_mem_sel,
    input  logic [31:0]      cfg_base_addr,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_last,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             abort_i,
    output logic [2:0]       mem_sel_o,
    output logic             wr_en_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_data_o,
    output logic             start_o,
    input  logic             done_i,
    input  logic             out_valid_i,
    output logic             busy_o,
    output logic             evt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] out_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] STRIDE  = 32'(ADDR_STRIDE);
    localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic             r_cfg_ready;
    logic [2:0]       r_mem_sel;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_idx;
    logic             r_last;
    logic [31:0]      r_addr;
    logic             r_wr_en;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_data;
    logic             r_start;
    logic             r_evt;
    logic             r_err;
    logic [31:0]      r_wd;
    logic [CNT_W-1:0] r_out_count;

    logic             w_cfg_fire;
    logic             w_beat_fire;
    logic             w_last_beat;
    logic [31:0]      w_wd_inc;
    logic             w_timeout;

    // Abort suppresses both handshakes so a descriptor or beat offered in the
    // abort cycle is dropped rather than half-applied.
    assign w_cfg_fire  = cfg_valid && r_cfg_ready && (r_state == S_IDLE) && !abort_i;
    assign w_beat_fire = in_valid && (r_state == S_LOAD) && !abort_i;
    assign w_last_beat = (r_idx == (r_count - CNT_W'(1)));
    assign w_wd_inc    = r_wd + 32'd1;
    assign w_timeout   = (TIMEOUT != 32'd0) && (w_wd_inc == TIMEOUT);

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cfg_fire) begin
                    if (cfg_count != '0) w_next = S_LOAD;
                    else if (cfg_last)   w_next = S_START;
                end
            end
            S_LOAD: begin
                if (w_beat_fire && w_last_beat) w_next = r_last ? S_START : S_IDLE;
            end
            S_START: w_next = S_RUN;
            S_RUN: begin
                if (done_i)         w_next = S_DONE;
                else if (w_timeout) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort_i) w_next = S_IDLE;
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cfg_ready <= (w_next == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_sel   <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_start     <= 1'b0;
            r_evt       <= 1'b0;
            r_err       <= 1'b0;
            r_wd        <= '0;
            r_out_count <= '0;
        end else begin
            r_wr_en <= w_beat_fire;
            r_start <= (r_state == S_START) && !abort_i;
            r_evt   <= (w_next == S_DONE) || (w_next == S_ERR);

            if (w_cfg_fire) begin
                r_mem_sel <= cfg_mem_sel;
                r_count   <= cfg_count;
                r_last    <= cfg_last;
                r_addr    <= cfg_base_addr;
                r_idx     <= '0;
            end else if (w_beat_fire) begin
                r_wr_addr <= r_addr;
                r_wr_data <= in_data;
                r_addr    <= r_addr + STRIDE;
                r_idx     <= r_idx + CNT_W'(1);
            end

            if (w_cfg_fire)            r_err <= 1'b0;
            else if (w_next == S_ERR)  r_err <= 1'b1;

            if (r_state == S_START) begin
                r_wd        <= '0;
                r_out_count <= '0;
            end else if (r_state == S_RUN) begin
                r_wd <= w_wd_inc;
                if (out_valid_i && (r_out_count != '1)) r_out_count <= r_out_count + CNT_W'(1);
            end
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign in_ready    = (r_state == S_LOAD);
    assign mem_sel_o   = r_mem_sel;
    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign start_o     = r_start;
    assign busy_o      = (r_state != S_IDLE);
    assign evt_o       = r_evt;
    assign err_o       = r_err;
    assign out_count_o = r_out_count;

endmodule
